// File: rtl/text_writer_if.sv
// Byte-stream and VRAM write-port bundle for text_writer.
// master: byte source / observer side; slave: the writer itself.
interface text_writer_if;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [10:0] vram_addr;
  logic [7:0]  vram_wdata;
  logic        vram_we;
  logic [5:0]  cursor_col;
  logic [4:0]  cursor_row;

  modport master (
    output in_data, in_valid,
    input  in_ready, vram_addr, vram_wdata, vram_we,
    input  cursor_col, cursor_row
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, vram_addr, vram_wdata, vram_we,
    output cursor_col, cursor_row
  );
endinterface

// File: rtl/text_writer.sv
// Text-mode character writer: bytes in, VRAM writes and cursor out.
// Optional TEXT_WRITER_CLEARLINE_EN: clear destination row on line advance.
module text_writer #(
  parameter int COLS = 40,
  parameter int ROWS = 30
) (
  input logic         clk,
  input logic         reset,
  text_writer_if.slave bus
);

`ifdef TEXT_WRITER_CLEARLINE_EN
  typedef enum logic [1:0] {IDLE, CLRROW, CLRALL} state_t;
`else
  typedef enum logic [1:0] {IDLE, CLRALL} state_t;
`endif

  localparam logic [5:0] LASTCOL = 6'(COLS - 1);
  localparam logic [4:0] LASTROW = 5'(ROWS - 1);
  localparam logic [7:0] SPACE   = 8'h20;

  state_t      state, state_n;
  logic [5:0]  col, col_n;
  logic [4:0]  row, row_n, row_inc;
  logic [10:0] cnt, cnt_n;
  logic        we, we_n;
  logic [10:0] addr, addr_n;
  logic [7:0]  wdata, wdata_n;
  logic        is_print, is_cr, is_lf, is_bs, is_ff;
`ifdef TEXT_WRITER_CLEARLINE_EN
  logic        pend, pend_n;
`endif

  assign is_print = (bus.in_data >= 8'h20) && (bus.in_data <= 8'h7E);
  assign is_cr    = bus.in_data == 8'h0D;
  assign is_lf    = bus.in_data == 8'h0A;
  assign is_bs    = bus.in_data == 8'h08;
  assign is_ff    = bus.in_data == 8'h0C;
  assign row_inc  = (row == LASTROW) ? 5'd0 : row + 5'd1;

  assign bus.in_ready   = (state == IDLE) && !reset;
  assign bus.vram_addr  = addr;
  assign bus.vram_wdata = wdata;
  assign bus.vram_we    = we;
  assign bus.cursor_col = col;
  assign bus.cursor_row = row;

  // State register; clears abort on reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Cursor, clear counter and registered write port
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col   <= '0;
      row   <= '0;
      cnt   <= '0;
      we    <= 1'b0;
      addr  <= '0;
      wdata <= '0;
`ifdef TEXT_WRITER_CLEARLINE_EN
      pend  <= 1'b0;
`endif
    end else begin
      col   <= col_n;
      row   <= row_n;
      cnt   <= cnt_n;
      we    <= we_n;
      addr  <= addr_n;
      wdata <= wdata_n;
`ifdef TEXT_WRITER_CLEARLINE_EN
      pend  <= pend_n;
`endif
    end
  end

  // Byte decode and clear sequencing; a clear issues its first
  // write on the entering edge, so the busy span equals the writes
  always_comb begin
    state_n = state;
    col_n   = col;
    row_n   = row;
    cnt_n   = cnt;
    we_n    = 1'b0;
    addr_n  = addr;
    wdata_n = wdata;
`ifdef TEXT_WRITER_CLEARLINE_EN
    pend_n  = pend;
`endif
    unique case (state)
      IDLE: begin
        if (bus.in_valid) begin
          unique case (1'b1)
            is_print: begin
              we_n    = 1'b1;
              addr_n  = {row, col};
              wdata_n = bus.in_data;
              if (col == LASTCOL) begin
                col_n = '0;
                row_n = row_inc;
`ifdef TEXT_WRITER_CLEARLINE_EN
                state_n = CLRROW;
                pend_n  = 1'b1;
                cnt_n   = '0;
`endif
              end else begin
                col_n = col + 6'd1;
              end
            end
            is_cr: col_n = '0;
            is_lf: begin
              row_n = row_inc;
`ifdef TEXT_WRITER_CLEARLINE_EN
              state_n = CLRROW;
              we_n    = 1'b1;
              addr_n  = {row_inc, 6'd0};
              wdata_n = SPACE;
              cnt_n   = '0;
`endif
            end
            is_bs: begin
              if (col != 6'd0) col_n = col - 6'd1;
            end
            is_ff: begin
              col_n   = '0;
              row_n   = '0;
              state_n = CLRALL;
              we_n    = 1'b1;
              addr_n  = '0;
              wdata_n = SPACE;
              cnt_n   = '0;
            end
            default: ;
          endcase
        end
      end
`ifdef TEXT_WRITER_CLEARLINE_EN
      CLRROW: begin
        if (pend) begin
          pend_n  = 1'b0;
          we_n    = 1'b1;
          addr_n  = {row, 6'd0};
          wdata_n = SPACE;
          cnt_n   = '0;
        end else if (cnt[5:0] == 6'h3F) begin
          state_n = IDLE;
        end else begin
          we_n    = 1'b1;
          addr_n  = {row, cnt[5:0] + 6'd1};
          wdata_n = SPACE;
          cnt_n   = cnt + 11'd1;
        end
      end
`endif
      CLRALL: begin
        if (cnt == 11'h7FF) begin
          state_n = IDLE;
        end else begin
          we_n    = 1'b1;
          addr_n  = cnt + 11'd1;
          wdata_n = SPACE;
          cnt_n   = cnt + 11'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_text_writer.sv
// Self-checking bench for text_writer: vector table, directed
// corner sequences and random bytes against a cursor/RAM model.
module tb_text_writer;
  localparam int COLS = 40;
  localparam int ROWS = 30;
`ifdef TEXT_WRITER_CLEARLINE_EN
  localparam bit CL = 1'b1;
`else
  localparam bit CL = 1'b0;
`endif
  localparam int LFW = CL ? 64 : 0;

  logic clk = 1'b0;
  logic reset;
  int tests = 0;
  int fails = 0;

  text_writer_if bus();

  text_writer #(.COLS(COLS), .ROWS(ROWS)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    logic [10:0] a;
    logic [7:0]  d;
    int          c;
  } wr_t;

  wr_t got[$];
  wr_t exp[$];
  int  cyc = 0;

  always @(negedge clk) begin
    cyc++;
    if (bus.vram_we === 1'b1)
      got.push_back('{bus.vram_addr, bus.vram_wdata, cyc});
  end

  // reference model: cursor plus list of expected writes
  int mc, mr, mbusy;

  function automatic void push(int a, logic [7:0] d);
    exp.push_back('{11'(a), d, 0});
  endfunction

  function automatic void mstep(logic [7:0] b);
    mbusy = 0;
    if (b >= 8'h20 && b <= 8'h7E) begin
      push(mr * 64 + mc, b);
      mc++;
      if (mc == COLS) begin
        mc = 0;
        mr = (mr + 1) % ROWS;
        if (CL) begin
          for (int i = 0; i < 64; i++) push(mr * 64 + i, 8'h20);
          mbusy = 65;
        end
      end
    end else if (b == 8'h0D) begin
      mc = 0;
    end else if (b == 8'h0A) begin
      mr = (mr + 1) % ROWS;
      if (CL) begin
        for (int i = 0; i < 64; i++) push(mr * 64 + i, 8'h20);
        mbusy = 64;
      end
    end else if (b == 8'h08) begin
      if (mc > 0) mc--;
    end else if (b == 8'h0C) begin
      mc = 0;
      mr = 0;
      for (int i = 0; i < 2048; i++) push(i, 8'h20);
      mbusy = 2048;
    end
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    mc = 0;
    mr = 0;
    got.delete();
    exp.delete();
  endtask

  task automatic send(logic [7:0] b);
    int t = 0;
    while (bus.in_ready !== 1'b1 && t < 4000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 4000) chk("ready_timeout", 0, 1);
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    mstep(b);
  endtask

  task automatic settle(output int busy);
    int t = 0;
    busy = 0;
    while (bus.in_ready !== 1'b1 && t < 4000) begin
      busy++;
      @(negedge clk);
      t++;
    end
    if (t >= 4000) chk("idle_timeout", 0, 1);
    #1;
  endtask

  task automatic cmp_writes(string nm);
    int bad = 0;
    chk({nm, "_wcount"}, got.size(), exp.size());
    for (int i = 0; i < got.size() && i < exp.size(); i++)
      if (got[i].a !== exp[i].a || got[i].d !== exp[i].d) bad++;
    chk({nm, "_wdata"}, bad, 0);
    got.delete();
    exp.delete();
  endtask

  task automatic xfer(logic [7:0] b, string nm);
    int busy;
    send(b);
    settle(busy);
    chk({nm, "_busy"}, busy, mbusy);
    chk({nm, "_col"}, bus.cursor_col, mc);
    chk({nm, "_row"}, bus.cursor_row, mr);
    cmp_writes(nm);
  endtask

  typedef struct {
    logic [7:0] b;
    logic [5:0] ecol;
    logic [4:0] erow;
    int         nwr;
  } vec_t;

  vec_t vt[13];

  initial begin
    int busy, t, r;
    logic [7:0] b;
    vt[0]  = '{8'h41, 6'd1, 5'd0, 1};
    vt[1]  = '{8'h42, 6'd2, 5'd0, 1};
    vt[2]  = '{8'h0D, 6'd0, 5'd0, 0};
    vt[3]  = '{8'h0A, 6'd0, 5'd1, LFW};
    vt[4]  = '{8'h78, 6'd1, 5'd1, 1};
    vt[5]  = '{8'h08, 6'd0, 5'd1, 0};
    vt[6]  = '{8'h08, 6'd0, 5'd1, 0};
    vt[7]  = '{8'h01, 6'd0, 5'd1, 0};
    vt[8]  = '{8'h7F, 6'd0, 5'd1, 0};
    vt[9]  = '{8'h1F, 6'd0, 5'd1, 0};
    vt[10] = '{8'h7E, 6'd1, 5'd1, 1};
    vt[11] = '{8'h20, 6'd2, 5'd1, 1};
    vt[12] = '{8'h0D, 6'd0, 5'd1, 0};

    // reset state
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    reset = 1'b1;
    @(negedge clk);
    chk("rst_we", bus.vram_we, 0);
    chk("rst_addr", bus.vram_addr, 0);
    chk("rst_wdata", bus.vram_wdata, 0);
    chk("rst_col", bus.cursor_col, 0);
    chk("rst_row", bus.cursor_row, 0);
    chk("rst_ready_low", bus.in_ready, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ready_high", bus.in_ready, 1);
    mc = 0;
    mr = 0;
    got.delete();
    exp.delete();

    // vector table
    for (int i = 0; i < 13; i++) begin
      send(vt[i].b);
      settle(busy);
      chk($sformatf("vec%0d_col", i), bus.cursor_col, vt[i].ecol);
      chk($sformatf("vec%0d_row", i), bus.cursor_row, vt[i].erow);
      chk($sformatf("vec%0d_nwr", i), got.size(), vt[i].nwr);
      cmp_writes($sformatf("vec%0d", i));
    end

    // back-to-back "AB"
    do_reset();
    bus.in_data  = 8'h41;
    bus.in_valid = 1'b1;
    @(negedge clk);
    chk("ab_ready1", bus.in_ready, 1);
    bus.in_data = 8'h42;
    @(negedge clk);
    chk("ab_ready2", bus.in_ready, 1);
    bus.in_valid = 1'b0;
    mstep(8'h41);
    mstep(8'h42);
    @(negedge clk);
    #1;
    chk("ab_nwr", got.size(), 2);
    while (got.size() < 2) got.push_back('{11'h7FF, 8'hFF, 0});
    chk("ab_a0", got[0].a, 11'h000);
    chk("ab_d0", got[0].d, 8'h41);
    chk("ab_a1", got[1].a, 11'h001);
    chk("ab_d1", got[1].d, 8'h42);
    chk("ab_consec", got[1].c - got[0].c, 1);
    chk("ab_col", bus.cursor_col, 2);
    chk("ab_row", bus.cursor_row, 0);
    cmp_writes("ab");

    // autowrap at (39,3)
    do_reset();
    for (int i = 0; i < 3; i++) xfer(8'h0A, "zw_lf");
    for (int i = 0; i < 39; i++) xfer(8'h61, "zw_fill");
    chk("zw_precol", bus.cursor_col, 39);
    send(8'h5A);
    settle(busy);
    chk("zw_busy", busy, CL ? 65 : 0);
    if (got.size() == 0) got.push_back('{11'h7FF, 8'hFF, 0});
    chk("zw_addr", got[0].a, 11'h0E7);
    chk("zw_data", got[0].d, 8'h5A);
    chk("zw_col", bus.cursor_col, 0);
    chk("zw_row", bus.cursor_row, 4);
    if (got.size() == 1 + LFW && got.size() > exp.size()) got.pop_back();
    cmp_writes("zw");

    // LF wrap from last row
    do_reset();
    for (int i = 0; i < 29; i++) xfer(8'h0A, "lfw_pre");
    chk("lfw_row29", bus.cursor_row, 29);
    send(8'h0A);
    settle(busy);
    chk("lfw_row0", bus.cursor_row, 0);
    chk("lfw_nwr", got.size(), LFW);
    cmp_writes("lfw");

    // BS and CR
    do_reset();
    for (int i = 0; i < 5; i++) xfer(8'h0A, "bs_pre");
    xfer(8'h08, "bs_at0");
    chk("bs_at0_c", bus.cursor_col, 0);
    for (int i = 0; i < 7; i++) xfer(8'h30 + 8'(i), "bs_fill");
    xfer(8'h08, "bs_at7");
    chk("bs_at7_c", bus.cursor_col, 6);
    chk("bs_at7_r", bus.cursor_row, 5);
    xfer(8'h0D, "cr");
    chk("cr_c", bus.cursor_col, 0);

    // full clear, then ignored byte
    xfer(8'h0C, "ff");
    chk("ff_col", bus.cursor_col, 0);
    chk("ff_row", bus.cursor_row, 0);
    send(8'h0C);
    settle(busy);
    chk("ff_busy2048", busy, 2048);
    chk("ff_n2048", got.size(), 2048);
    cmp_writes("ff2");
    xfer(8'h01, "ign");

    // reset in the middle of a full clear
    xfer(8'h4B, "rc_pre");
    send(8'h0C);
    t = 0;
    while (!(bus.vram_we === 1'b1 && bus.vram_addr == 11'h200) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("rc_reach200", t < 3000, 1);
    reset = 1'b1;
    #1;
    chk("rc_we", bus.vram_we, 0);
    chk("rc_col", bus.cursor_col, 0);
    chk("rc_row", bus.cursor_row, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rc_ready", bus.in_ready, 1);
    mc = 0;
    mr = 0;
    got.delete();
    exp.delete();
    xfer(8'h51, "rc_post");

    // random bytes against the model
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      if (r < 70)      b = 8'($urandom_range(32, 126));
      else if (r < 78) b = 8'h0D;
      else if (r < 86) b = 8'h0A;
      else if (r < 93) b = 8'h08;
      else if (r < 98) b = 8'($urandom_range(128, 255));
      else             b = 8'h0C;
      xfer(b, $sformatf("rnd%0d_%02h", i, b));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
